// File: rtl/i2c_master_ctrl.sv
// Byte-oriented I2C master sequencer driving open-drain SCL/SDA enables.
// Handles START, address, write/read data with ACK/NACK, and STOP.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_addr,
    input  logic             cmd_rw,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             nack_err,
    output logic             busy,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             sda_in
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
    } state_t;

    state_t             state_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic               phase_reg;      // 0 = SCL low phase, 1 = SCL high phase
    logic [2:0]         bit_cnt_reg;    // bit index in a byte, sub-stage in STOP
    logic [7:0]         shift_reg;
    logic [LEN_W-1:0]   len_cnt_reg;
    logic               rw_reg;
    logic               nack_flag_reg;
    logic               loaded_reg;     // write byte fetched for the current WR_BYTE

    logic               tick;
    logic               last_bit;
    logic [7:0]         shift_in;
    logic [LEN_W-1:0]   len_dec;
    logic [LEN_W-1:0]   ack_len;

    assign tick     = (div_cnt_reg == DIV_LAST);
    assign last_bit = (bit_cnt_reg == 3'd7);
    assign shift_in = {shift_reg[6:0], sda_in};
    assign len_dec  = len_cnt_reg - LEN_W'(1);
    // The address ACK does not consume a data byte; data ACKs do.
    assign ack_len  = (state_reg == ADDR_ACK) ? len_cnt_reg : len_dec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            div_cnt_reg   <= '0;
            phase_reg     <= 1'b0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            len_cnt_reg   <= '0;
            rw_reg        <= 1'b0;
            nack_flag_reg <= 1'b0;
            loaded_reg    <= 1'b0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            wr_ready      <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            done          <= 1'b0;
            nack_err      <= 1'b0;
            scl_oe        <= 1'b0;
            sda_oe        <= 1'b0;
        end else begin
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (state_reg != IDLE) begin
                div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        state_reg     <= START;
                        cmd_ready     <= 1'b0;
                        busy          <= 1'b1;
                        scl_oe        <= 1'b0;
                        sda_oe        <= 1'b1;
                        div_cnt_reg   <= '0;
                        shift_reg     <= {cmd_addr, cmd_rw};
                        rw_reg        <= cmd_rw;
                        len_cnt_reg   <= cmd_len;
                        nack_flag_reg <= 1'b0;
                        nack_err      <= 1'b0;
                    end
                end

                START: begin
                    if (tick) begin
                        state_reg   <= ADDR;
                        scl_oe      <= 1'b1;
                        sda_oe      <= ~shift_reg[7];
                        phase_reg   <= 1'b0;
                        bit_cnt_reg <= '0;
                    end
                end

                ADDR, WR_BYTE: begin
                    if (state_reg == WR_BYTE && !loaded_reg) begin
                        // SCL stays low until the write source supplies a byte.
                        div_cnt_reg <= '0;
                        if (wr_valid) begin
                            shift_reg  <= wr_data;
                            wr_ready   <= 1'b1;
                            sda_oe     <= ~wr_data[7];
                            loaded_reg <= 1'b1;
                        end
                    end else if (tick) begin
                        if (!phase_reg) begin
                            phase_reg <= 1'b1;
                            scl_oe    <= 1'b0;
                        end else begin
                            phase_reg <= 1'b0;
                            scl_oe    <= 1'b1;
                            if (last_bit) begin
                                state_reg <= (state_reg == ADDR) ? ADDR_ACK : WR_ACK;
                                sda_oe    <= 1'b0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                sda_oe      <= ~shift_reg[6];
                            end
                        end
                    end
                end

                ADDR_ACK, WR_ACK: begin
                    if (tick) begin
                        if (!phase_reg) begin
                            phase_reg <= 1'b1;
                            scl_oe    <= 1'b0;
                        end else begin
                            phase_reg   <= 1'b0;
                            scl_oe      <= 1'b1;
                            bit_cnt_reg <= '0;
                            len_cnt_reg <= ack_len;
                            if (sda_in || ack_len == '0) begin
                                if (sda_in) nack_flag_reg <= 1'b1;
                                state_reg <= STOP;
                                sda_oe    <= 1'b1;
                            end else if (rw_reg) begin
                                state_reg <= RD_BYTE;
                                sda_oe    <= 1'b0;
                            end else begin
                                state_reg <= WR_BYTE;
                                if (wr_valid) begin
                                    shift_reg  <= wr_data;
                                    wr_ready   <= 1'b1;
                                    sda_oe     <= ~wr_data[7];
                                    loaded_reg <= 1'b1;
                                end else begin
                                    sda_oe     <= 1'b0;
                                    loaded_reg <= 1'b0;
                                end
                            end
                        end
                    end
                end

                RD_BYTE: begin
                    if (tick) begin
                        if (!phase_reg) begin
                            phase_reg <= 1'b1;
                            scl_oe    <= 1'b0;
                        end else begin
                            phase_reg <= 1'b0;
                            scl_oe    <= 1'b1;
                            shift_reg <= shift_in;
                            if (last_bit) begin
                                state_reg <= RD_ACK;
                                rd_data   <= shift_in;
                                rd_valid  <= 1'b1;
                                // ACK while more bytes follow, NACK the final one.
                                sda_oe    <= (len_cnt_reg != LEN_W'(1));
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                end

                RD_ACK: begin
                    if (tick) begin
                        if (!phase_reg) begin
                            phase_reg <= 1'b1;
                            scl_oe    <= 1'b0;
                        end else begin
                            phase_reg   <= 1'b0;
                            scl_oe      <= 1'b1;
                            bit_cnt_reg <= '0;
                            len_cnt_reg <= len_dec;
                            if (len_dec == '0) begin
                                state_reg <= STOP;
                                sda_oe    <= 1'b1;
                            end else begin
                                state_reg <= RD_BYTE;
                                sda_oe    <= 1'b0;
                            end
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        case (bit_cnt_reg)
                            3'd0:    scl_oe <= 1'b0;
                            3'd1:    sda_oe <= 1'b0;
                            default: begin
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                                cmd_ready <= 1'b1;
                                done      <= 1'b1;
                                nack_err  <= nack_flag_reg;
                            end
                        endcase
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
